cpu_oci_dct_sequencer: RTL and testbench
========================================

Name: cpu_oci_dct_sequencer

Overview:
- Packs 2-bit debug trace atoms from the Nios II OCI into a 30-bit DCT buffer holding up to 15 atoms, with a 4-bit atom count.
- Hands completed or flushed buffers to the trace-capture path over a valid/ready handshake.
- Sequences end-of-test draining, and exposes the live dct_buffer/dct_count to the OCI test bench.
- Sits between the OCI trace source and the on-chip trace FIFO.

Parameters:
- ATOMS, 15, atoms per buffer (buffer width = 2*ATOMS = 30; count width 4)
- AUTO_FLUSH_IDLE, 64, idle cycles with a partial buffer before an automatic flush; 0 disables auto-flush

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- atom_valid  in  1  atom_data valid this cycle
- atom_data  in  2  trace atom
- flush_req  in  1  single-cycle request to flush the partial buffer
- test_ending  in  1  level; begin the end-of-test drain
- out_valid  out  1  out_data/out_count held valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  30  packed buffer, atom n at bits [2n+1:2n]
- out_count  out  4  atoms in out_data (1..15)
- dct_buffer  out  30  live packing buffer
- dct_count  out  4  live atom count (0..15)
- overflow  out  1  sticky; an atom was dropped
- test_has_ended  out  1  drain complete; sticky until reset

Behaviour:
- Reset values: all outputs 0; state RUN; idle counter 0.
- Reset applies on any clock edge, including mid-transfer. A pending out_valid is abandoned.
- Storage:
  - One packing buffer (dct_buffer/dct_count).
  - One output holding register (out_data/out_count/out_valid).
- Accept: in RUN or FLUSH_PEND, an atom with dct_count < 15 is written at slot dct_count; dct_count increments next cycle.
- Transfer (buffer to holding register) occurs when the holding register is free, or is freeing this cycle (out_valid && out_ready), and either:
  - dct_count == 15, or
  - a flush is pending and dct_count > 0.
- On a transfer:
  - out_valid = 1 the next cycle.
  - The buffer clears.
  - An atom accepted in the same cycle lands in slot 0 with dct_count = 1.
  - Zero latency added: a full buffer with a free output appears on out_valid 1 cycle after the 15th atom.
- Stall: if dct_count == 15, no transfer is possible, and atom_valid = 1:
  - The atom is dropped and overflow is set.
  - The buffer is unchanged.
- Handshake:
  - out_data and out_count are stable while out_valid && !out_ready.
  - out_valid drops the cycle after acceptance unless a new transfer occurs in that same cycle (back-to-back allowed).
- flush_req:
  - Sets the flush-pending flag, which is cleared by the transfer.
  - If dct_count == 0, the flag clears immediately with no output.
  - A flush_req in the same cycle as an accepted atom includes that atom.
- Auto-flush: the idle counter counts cycles with dct_count > 0 and no atom_valid. Reaching AUTO_FLUSH_IDLE acts as flush_req. Any atom resets the counter.
- States:
  - RUN → FLUSH_PEND on test_ending.
  - FLUSH_PEND: atoms are still accepted this cycle only; flush forced. Once the buffer is empty, out_valid == 0, and no atom arrived, go to HALT.
  - HALT: atom_valid ignored (no overflow); test_has_ended = 1; leaves only on reset.
- test_ending deasserting in FLUSH_PEND does not abort the drain.

Optional Feature:
- Macro: CPU_OCI_DCT_DROP_CNT_EN.
- Defined: adds output drop_count[7:0], an 8-bit saturating count of dropped atoms (sticks at 255). Reset 0. overflow = (drop_count != 0).
- Undefined: port absent; overflow is a plain sticky flag.

Decomposition:
- Shared package cpu_oci_dct_pkg holds:
  - the ATOM_W = 2, DCT_BUF_W = 30, DCT_CNT_W = 4 constants;
  - the state enum {RUN, FLUSH_PEND, HALT};
  - the atom encodings (2'b00 none, 2'b01 taken, 2'b10 not-taken, 2'b11 exception).
- One natural sub-module: cpu_oci_dct_outreg, the holding register with valid/ready.

Test Plan:
- 15 atoms 2'b01 back-to-back, out_ready = 1 → out_valid one cycle after the 15th, out_data = 30'h15555555, out_count = 15, dct_count = 0.
- 3 atoms (01, 10, 11), then flush_req → out_data = 30'h00000039, out_count = 3. A flush_req with dct_count = 0 produces no output.
- out_ready = 0, 31 atoms → first 15 held stable, second 15 fill the buffer, 31st dropped with overflow = 1. Release out_ready → both buffers emitted in order, out_valid high 2 consecutive cycles.
- 5 atoms then idle 64 cycles (AUTO_FLUSH_IDLE = 64) → auto-flush, out_count = 5.
- 7 atoms, test_ending = 1 → one output with out_count = 7, then test_has_ended = 1. Further atoms are ignored with overflow = 0.
- Reset asserted with out_valid = 1 and dct_count = 9 → next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/cpu_oci_dct_pkg.sv
// Shared constants, FSM state and trace-atom encodings for the OCI DCT sequencer.
package cpu_oci_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_PEND = 2'd1,
        HALT       = 2'd2
    } dct_state_e;

    typedef enum logic [1:0] {
        ATOM_NONE      = 2'b00,
        ATOM_TAKEN     = 2'b01,
        ATOM_NOT_TAKEN = 2'b10,
        ATOM_EXCEPTION = 2'b11
    } dct_atom_e;

endpackage

// File: rtl/cpu_oci_dct_outreg.sv
// Output holding register for completed DCT buffers, presented on a valid/ready handshake.
module cpu_oci_dct_outreg
    import cpu_oci_dct_pkg::*;
#(
    parameter int DATA_W = DCT_BUF_W,
    parameter int CNT_W  = DCT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              free
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Free now, or being consumed this cycle, so a back-to-back load is legal.
    assign free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_count = count_q;

endmodule

// File: rtl/cpu_oci_dct_sequencer.sv
// Packs 2-bit OCI trace atoms into DCT buffers, hands them off, and sequences the end-of-test drain.
// Optional macro CPU_OCI_DCT_DROP_CNT_EN adds a saturating drop_count output.
module cpu_oci_dct_sequencer
    import cpu_oci_dct_pkg::*;
#(
    parameter int ATOMS           = 15,
    parameter int AUTO_FLUSH_IDLE = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        atom_valid,
    input  logic [ATOM_W-1:0]           atom_data,
    input  logic                        flush_req,
    input  logic                        test_ending,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ATOM_W*ATOMS-1:0]     out_data,
    output logic [DCT_CNT_W-1:0]        out_count,
    output logic [ATOM_W*ATOMS-1:0]     dct_buffer,
    output logic [DCT_CNT_W-1:0]        dct_count,
    output logic                        overflow,
    output logic                        test_has_ended
`ifdef CPU_OCI_DCT_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_count
`endif
);

    localparam int                   BUF_W     = ATOM_W * ATOMS;
    localparam logic [DCT_CNT_W-1:0] CNT_FULL  = DCT_CNT_W'(ATOMS);
    localparam logic [15:0]          IDLE_LAST = 16'((AUTO_FLUSH_IDLE > 0) ? AUTO_FLUSH_IDLE - 1 : 0);

    dct_state_e           state_q, state_d;
    logic [BUF_W-1:0]     buf_q, buf_d, merged_buf;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d, merged_cnt;
    logic                 flush_q, flush_d;
    logic [15:0]          idle_q, idle_d;
    logic                 ended_q, ended_d;
    logic                 take, full, fit, auto_fire, flush_now, xfer, drop, out_free;

    always_comb begin
        take = atom_valid && (state_q != HALT);
        full = (cnt_q == CNT_FULL);
        fit  = take && !full;

        // Buffer as it would look with this cycle's atom appended; a transfer ships this view.
        merged_buf = buf_q;
        for (int i = 0; i < ATOMS; i++) begin
            if (fit && (cnt_q == DCT_CNT_W'(i))) begin
                merged_buf[ATOM_W*i +: ATOM_W] = atom_data;
            end
        end
        merged_cnt = cnt_q + DCT_CNT_W'(fit);

        auto_fire = 1'b0;
        idle_d    = '0;
        if (AUTO_FLUSH_IDLE != 0 && !atom_valid && cnt_q != '0) begin
            if (idle_q == IDLE_LAST) begin
                auto_fire = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end

        flush_now = flush_q || flush_req || auto_fire || (state_q == FLUSH_PEND);
        xfer      = out_free && ((merged_cnt == CNT_FULL) || (flush_now && merged_cnt != '0));
        drop      = take && full && !xfer;

        if (xfer) begin
            buf_d = '0;
            cnt_d = '0;
            if (take && full) begin
                buf_d[ATOM_W-1:0] = atom_data;
                cnt_d             = DCT_CNT_W'(1);
            end
        end else begin
            buf_d = merged_buf;
            cnt_d = merged_cnt;
        end

        if (xfer || merged_cnt == '0) begin
            flush_d = 1'b0;
        end else begin
            flush_d = flush_q || flush_req || auto_fire;
        end

        state_d = state_q;
        ended_d = ended_q;
        unique case (state_q)
            RUN: begin
                if (test_ending) begin
                    state_d = FLUSH_PEND;
                end
            end
            FLUSH_PEND: begin
                if (cnt_q == '0 && !out_valid && !atom_valid) begin
                    state_d = HALT;
                    ended_d = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            idle_q  <= '0;
            ended_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            idle_q  <= idle_d;
            ended_q <= ended_d;
        end
    end

    cpu_oci_dct_outreg #(
        .DATA_W (BUF_W),
        .CNT_W  (DCT_CNT_W)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (xfer),
        .load_data  (merged_buf),
        .load_count (merged_cnt),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .free       (out_free)
    );

`ifdef CPU_OCI_DCT_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
    assign overflow   = (drop_cnt_q != 8'd0);
`else
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q || drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_cpu_oci_dct_sequencer.sv
// Bench for cpu_oci_dct_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_cpu_oci_dct_sequencer;

    localparam int IDLE = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'b00;
    logic        flush_req = 1'b0;
    logic        test_ending = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_has_ended;
`ifdef CPU_OCI_DCT_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    cpu_oci_dct_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
`ifdef CPU_OCI_DCT_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: atom queue, holding slot, flags.
    logic [1:0]  m_buf[$];
    bit          m_hv;
    logic [29:0] m_hd;
    logic [3:0]  m_hc;
    bit          m_flush, m_drain, m_halt, m_ovf;
    int          m_idle, m_drops;

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] v = '0;
        for (int i = 0; i < q.size(); i++) v = v | (30'(q[i]) << (2 * i));
        return v;
    endfunction

    task automatic model_step();
        logic [1:0] pend[$];
        bit take, free, fire, send;
        int old_n;
        if (reset) begin
            m_buf.delete();
            m_hv = 0; m_hd = '0; m_hc = '0;
            m_flush = 0; m_drain = 0; m_halt = 0; m_ovf = 0;
            m_idle = 0; m_drops = 0;
            return;
        end
        take  = atom_valid && !m_halt;
        free  = !m_hv || out_ready;
        old_n = m_buf.size();
        pend  = m_buf;
        if (take && old_n < 15) pend.push_back(atom_data);
        fire = 0;
        if (atom_valid || old_n == 0) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == IDLE) begin
                fire = 1;
                m_idle = 0;
            end
        end
        send = free && (pend.size() == 15 ||
                        ((m_flush || flush_req || fire || m_drain) && pend.size() > 0));
        if (m_drain && old_n == 0 && !m_hv && !atom_valid) begin
            m_drain = 0;
            m_halt = 1;
        end else if (!m_drain && !m_halt && test_ending) begin
            m_drain = 1;
        end
        if (send) begin
            m_hv = 1; m_hd = pack(pend); m_hc = 4'(pend.size());
        end else if (m_hv && out_ready) begin
            m_hv = 0;
        end
        m_flush = (send || pend.size() == 0) ? 0 : (m_flush || flush_req || fire);
        if (send) begin
            m_buf.delete();
            if (take && old_n == 15) m_buf.push_back(atom_data);
        end else begin
            m_buf = pend;
            if (take && old_n == 15) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_hv));
        chk("out_data", 32'(out_data), 32'(m_hd));
        chk("out_count", 32'(out_count), 32'(m_hc));
        chk("dct_buffer", 32'(dct_buffer), 32'(pack(m_buf)));
        chk("dct_count", 32'(dct_count), 32'(m_buf.size()));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_halt));
`ifdef CPU_OCI_DCT_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_drops));
        chk("overflow", 32'(overflow), 32'(m_drops != 0));
`else
        chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int idle_n, seen, waited;

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dct_count", 32'(dct_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Full buffer of taken atoms, consumer always ready
        out_ready = 1'b1;
        atom_data = 2'b01;
        for (int i = 0; i < 15; i++) begin
            atom_valid = 1'b1;
            tick();
        end
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_data", 32'(out_data), 32'h15555555);
        chk("full_count", 32'(out_count), 32'd15);
        chk("full_dct_count", 32'(dct_count), 32'd0);
        atom_valid = 1'b0;
        tick();
        chk("full_drop_valid", 32'(out_valid), 32'd0);

        // Three atoms then flush_req
        atom_valid = 1'b1;
        atom_data = 2'b01; tick();
        atom_data = 2'b10; tick();
        atom_data = 2'b11; tick();
        atom_valid = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd1);
        chk("flush_data", 32'(out_data), 32'h00000039);
        chk("flush_count", 32'(out_count), 32'd3);
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("empty_flush_valid", 32'(out_valid), 32'd0);
        tick();
        chk("empty_flush_valid2", 32'(out_valid), 32'd0);

        // Backpressure: 31 atoms with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'($urandom);
            tick();
        end
        atom_valid = 1'b0;
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_dct_count", 32'(dct_count), 32'd15);
        chk("bp_out_count", 32'(out_count), 32'd15);
        chk("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_count", 32'(out_count), 32'd15);
        tick();
        chk("bp_done_valid", 32'(out_valid), 32'd0);

        // Auto-flush after idle period
        for (int i = 0; i < 5; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'($urandom);
            tick();
        end
        atom_valid = 1'b0;
        idle_n = 0;
        while (!out_valid && idle_n < IDLE + 16) begin
            tick();
            idle_n++;
        end
        chk("auto_idle_cycles", 32'(idle_n), 32'(IDLE));
        chk("auto_count", 32'(out_count), 32'd5);
        tick();

        // Reset while a buffer is held and 9 atoms are packed
        out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'($urandom);
            tick();
        end
        atom_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_count", 32'(dct_count), 32'd9);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(dct_count), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // Random traffic with varying density and backpressure
        for (int seg = 0; seg < 12; seg++) begin
            int dens;
            int rdy;
            dens = $urandom_range(0, 100);
            rdy = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                atom_valid = ($urandom_range(0, 99) < dens);
                atom_data = 2'($urandom);
                flush_req = ($urandom_range(0, 49) == 0);
                out_ready = ($urandom_range(0, 99) < rdy);
                tick();
            end
        end
        atom_valid = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b1;

        // End-of-test drain
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'($urandom);
            tick();
        end
        atom_valid = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        seen = 0;
        waited = 0;
        while (!test_has_ended && waited < 20) begin
            tick();
            waited++;
            if (out_valid) begin
                seen++;
                chk("drain_count", 32'(out_count), 32'd7);
            end
        end
        chk("drain_outputs", 32'(seen), 32'd1);
        chk("drain_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 10; i++) begin
            atom_valid = 1'b1;
            atom_data = 2'($urandom);
            tick();
        end
        atom_valid = 1'b0;
        chk("halt_overflow", 32'(overflow), 32'd0);
        chk("halt_dct_count", 32'(dct_count), 32'd0);
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_ended", 32'(test_has_ended), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
